// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one registered ALU between two requesters (req0 =
// execute datapath, req1 = address/branch unit). Round-robin on conflict,
// one operation in flight, tagged result with a locally derived zero flag.
// Optional build macro: ALU_ARB_STATS_EN enables saturating per-requester
// grant counters; when undefined, grant0_cnt/grant1_cnt are tied to zero.
module alu_arbiter #(
  parameter int WIDTH   = 16,
  parameter int OPW     = 3,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OPW-1:0]   req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OPW-1:0]   req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [OPW-1:0]   alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_y,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_y,
  output logic             rsp_z,
  output logic             busy,
  output logic [15:0]      grant0_cnt,
  output logic [15:0]      grant1_cnt
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;

  // Counter only needs to reach ALU_LAT-1; keep at least one bit.
  localparam int CW = (ALU_LAT < 2) ? 1 : $clog2(ALU_LAT);
  localparam logic [CW-1:0] CNT_LAST = CW'(ALU_LAT - 1);

  state_e           state_q, state_d;
  logic [OPW-1:0]   alu_op_q, alu_op_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic             id_q, id_d;
  logic             last_grant_q, last_grant_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_y_q, rsp_y_d;
  logic             rsp_z_q, rsp_z_d;
  logic             gnt0, gnt1;

  // Round-robin grant: a lone requester wins; on conflict the one not
  // granted last time wins. Ready only while IDLE.
  always_comb begin
    gnt0       = req0_valid & (~req1_valid | last_grant_q);
    gnt1       = req1_valid & (~req0_valid | ~last_grant_q);
    req0_ready = (state_q == IDLE) & gnt0;
    req1_ready = (state_q == IDLE) & gnt1;
  end

  // Next-state and datapath capture for the IDLE -> EXEC -> DONE sequence.
  always_comb begin
    // NOTE: every target gets a hold/default value first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    alu_op_d     = alu_op_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    rsp_valid_d  = 1'b0;
    rsp_id_d     = rsp_id_q;
    rsp_y_d      = rsp_y_q;
    rsp_z_d      = rsp_z_q;
    unique case (state_q)
      IDLE: begin
        if (req0_ready) begin
          alu_op_d     = req0_op;
          alu_a_d      = req0_a;
          alu_b_d      = req0_b;
          id_d         = 1'b0;
          last_grant_d = 1'b0;
          cnt_d        = '0;
          state_d      = EXEC;
        end else if (req1_ready) begin
          alu_op_d     = req1_op;
          alu_a_d      = req1_a;
          alu_b_d      = req1_b;
          id_d         = 1'b1;
          last_grant_d = 1'b1;
          cnt_d        = '0;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = DONE;
      end
      DONE: begin
        rsp_valid_d = 1'b1;
        rsp_id_d    = id_q;
        rsp_y_d     = alu_y;
        rsp_z_d     = (alu_y == '0);
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset; reset abandons any operation.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q      <= IDLE;
      alu_op_q     <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_y_q      <= '0;
      rsp_z_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      alu_op_q     <= alu_op_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_y_q      <= rsp_y_d;
      rsp_z_q      <= rsp_z_d;
    end
  end

  assign alu_op    = alu_op_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_y     = rsp_y_q;
  assign rsp_z     = rsp_z_q;
  assign busy      = (state_q != IDLE);

`ifdef ALU_ARB_STATS_EN
  logic [15:0] grant0_cnt_q, grant0_cnt_d;
  logic [15:0] grant1_cnt_q, grant1_cnt_d;

  // Saturating handshake counters, one per requester.
  always_comb begin
    grant0_cnt_d = grant0_cnt_q;
    grant1_cnt_d = grant1_cnt_q;
    if (req0_ready && req0_valid && grant0_cnt_q != 16'hFFFF)
      grant0_cnt_d = grant0_cnt_q + 16'd1;
    if (req1_ready && req1_valid && grant1_cnt_q != 16'hFFFF)
      grant1_cnt_d = grant1_cnt_q + 16'd1;
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant0_cnt_q <= '0;
      grant1_cnt_q <= '0;
    end else begin
      grant0_cnt_q <= grant0_cnt_d;
      grant1_cnt_q <= grant1_cnt_d;
    end
  end

  assign grant0_cnt = grant0_cnt_q;
  assign grant1_cnt = grant1_cnt_q;
`else
  assign grant0_cnt = 16'd0;
  assign grant1_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: directed scenarios followed by random traffic.
// A transaction-level model predicts ready/busy/ALU drive each cycle and
// pushes expected responses into a queue; a monitor pops on rsp_valid.
module tb_alu_arbiter;

  localparam int W   = 16;
  localparam int LAT = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  logic [2:0]    req0_op, req1_op;
  logic [W-1:0]  req0_a, req0_b, req1_a, req1_b;
  logic [2:0]    alu_op;
  logic [W-1:0]  alu_a, alu_b;
  logic [W-1:0]  alu_y;
  logic          rsp_valid, rsp_id, rsp_z, busy;
  logic [W-1:0]  rsp_y;
  logic [15:0]   grant0_cnt, grant1_cnt;

  alu_arbiter #(.WIDTH(W), .OPW(3), .ALU_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_y(rsp_y), .rsp_z(rsp_z),
    .busy(busy), .grant0_cnt(grant0_cnt), .grant1_cnt(grant1_cnt)
  );

  always #5 clk = ~clk;

  // Arithmetic meaning of each opcode.
  function automatic logic [W-1:0] alu_f(logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a >> b[3:0];
      3'd3: return a << b[3:0];
      3'd4: return ~(a & b);
      3'd5: return a | b;
      3'd6: return b;
      default: return W'($signed(a) >>> b[3:0]);
    endcase
  endfunction

  // External single-cycle registered ALU.
  always @(posedge clk) alu_y <= alu_f(alu_op, alu_a, alu_b);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  typedef struct {
    bit           id;
    logic [W-1:0] y;
    int           cyc;
  } exp_t;

  exp_t exp_q[$];

  // Model state: when the shared ALU is free again, who won last, and
  // what was last issued to the ALU.
  int           next_free  = 0;
  bit           last       = 1'b1;
  logic [2:0]   iss_op     = '0;
  logic [W-1:0] iss_a      = '0;
  logic [W-1:0] iss_b      = '0;
  int           cnt0       = 0;
  int           cnt1       = 0;

  // Monitor: every rsp_valid must match the oldest outstanding prediction
  // in the cycle it was due.
  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      check("rsp_missing", 32'(exp_q[0].cyc), 32'(cyc));
      void'(exp_q.pop_front());
    end
    if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 32'(rsp_valid), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rsp_cycle", 32'(cyc), 32'(e.cyc));
        check("rsp_id", 32'(rsp_id), 32'(e.id));
        check("rsp_y", 32'(rsp_y), 32'(e.y));
        check("rsp_z", 32'(rsp_z), 32'(e.y == '0));
      end
    end
  end

  // Predictor: runs just after the monitor in each cycle.
  always @(negedge clk) begin
    #1;
    if (rst) begin
      exp_q.delete();
      next_free = 0;
      last      = 1'b1;
      iss_op    = '0;
      iss_a     = '0;
      iss_b     = '0;
      cnt0      = 0;
      cnt1      = 0;
    end else begin
      bit free, g0, g1;
      free = (cyc >= next_free);
      g0   = free && req0_valid && (!req1_valid || last);
      g1   = free && req1_valid && (!req0_valid || !last);
      check("req0_ready", 32'(req0_ready), 32'(g0));
      check("req1_ready", 32'(req1_ready), 32'(g1));
      check("busy", 32'(busy), 32'(!free));
      check("alu_op", 32'(alu_op), 32'(iss_op));
      check("alu_a", 32'(alu_a), 32'(iss_a));
      check("alu_b", 32'(alu_b), 32'(iss_b));
`ifdef ALU_ARB_STATS_EN
      check("grant0_cnt", 32'(grant0_cnt), 32'(cnt0 > 65535 ? 65535 : cnt0));
      check("grant1_cnt", 32'(grant1_cnt), 32'(cnt1 > 65535 ? 65535 : cnt1));
`else
      check("grant0_cnt", 32'(grant0_cnt), 32'd0);
      check("grant1_cnt", 32'(grant1_cnt), 32'd0);
`endif
      if (g0 || g1) begin
        exp_t e;
        iss_op = g0 ? req0_op : req1_op;
        iss_a  = g0 ? req0_a  : req1_a;
        iss_b  = g0 ? req0_b  : req1_b;
        e.id   = g1;
        e.y    = alu_f(iss_op, iss_a, iss_b);
        e.cyc  = cyc + 2 + LAT;
        exp_q.push_back(e);
        last      = g1;
        next_free = cyc + 2 + LAT;
        if (g0) cnt0++; else cnt1++;
      end
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive0(bit v, logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b);
    req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
  endtask

  task automatic drive1(bit v, logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b);
    req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive0(1'b0, 3'd0, '0, '0);
    drive1(1'b0, 3'd0, '0, '0);
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    do_reset();

    // Single request: ADD 3+4 from req0.
    drive0(1'b1, 3'd0, 16'h0003, 16'h0004);
    tick();
    drive0(1'b0, 3'd0, '0, '0);
    tick(4);

    // Zero flag: SUB equal operands, then ADD wrap-around, both from req1.
    drive1(1'b1, 3'd1, 16'h1234, 16'h1234);
    tick();
    drive1(1'b0, 3'd0, '0, '0);
    tick(4);
    drive1(1'b1, 3'd0, 16'hFFFF, 16'h0001);
    tick();
    drive1(1'b0, 3'd0, '0, '0);
    tick(4);

    // Conflict after reset: both valid continuously, alternating grants.
    do_reset();
    for (int i = 0; i < 15; i++) begin
      drive0(1'b1, 3'(i), 16'(i * 16'h0111), 16'(i + 1));
      drive1(1'b1, 3'(7 - i), 16'(16'hF00F - i), 16'(i));
      tick();
    end
    drive1(1'b0, 3'd0, '0, '0);

    // Back-to-back req0: handshake coincides with each rsp_valid.
    for (int i = 0; i < 10; i++) begin
      drive0(1'b1, 3'd5, 16'(i << 4), 16'h0001);
      tick();
    end
    drive0(1'b0, 3'd0, '0, '0);
    tick(4);

    // Reset during EXEC: aborted op must produce no response.
    drive1(1'b1, 3'd4, 16'hAAAA, 16'h5555);
    tick();
    drive1(1'b0, 3'd0, '0, '0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive0(1'b1, 3'd0, 16'h0010, 16'h0020);
    drive1(1'b1, 3'd0, 16'h0100, 16'h0200);
    tick();
    drive0(1'b0, 3'd0, '0, '0);
    drive1(1'b0, 3'd0, '0, '0);
    tick(4);

    // Random traffic with dropped requests and frequent zero results.
    for (int i = 0; i < 3000; i++) begin
      logic [W-1:0] a0, a1;
      a0 = 16'($urandom);
      a1 = 16'($urandom);
      drive0($urandom_range(0, 2) != 0, 3'($urandom),
             a0, ($urandom_range(0, 3) == 0) ? a0 : 16'($urandom));
      drive1($urandom_range(0, 2) != 0, 3'($urandom),
             a1, ($urandom_range(0, 3) == 0) ? a1 : 16'($urandom));
      if ($urandom_range(0, 499) == 0) rst = 1'b1;
      tick();
      rst = 1'b0;
    end
    drive0(1'b0, 3'd0, '0, '0);
    drive1(1'b0, 3'd0, '0, '0);
    tick(8);

    check("outstanding_rsp", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
